// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and helpers for the NUM_RD-read / 1-write register-file bank
package bram_pkg;

  typedef enum logic {ST_IDLE, ST_CLEAR} bram_clr_state_t;

  // byte_merge works on a fixed wide vector; callers size-cast in and out.
  localparam int MERGE_MAX_BYTES = 128;
  localparam int MERGE_MAX_WIDTH = MERGE_MAX_BYTES * 8;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic logic [MERGE_MAX_WIDTH-1:0] byte_merge(
    input logic [MERGE_MAX_WIDTH-1:0] old_data,
    input logic [MERGE_MAX_WIDTH-1:0] new_data,
    input logic [MERGE_MAX_BYTES-1:0] mask
  );
    logic [MERGE_MAX_WIDTH-1:0] merged;
    merged = old_data;
    for (int b = 0; b < MERGE_MAX_BYTES; b++) begin
      if (mask[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_clr_ctrl.sv
// rtl/bram_clr_ctrl.sv - clear sequencer: sweeps every entry to zero after reset and on request
module bram_clr_ctrl
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int ADDR_DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr_req,
  output logic                  o_busy,
  output logic                  o_clr_we,
  output logic [ADDR_WIDTH-1:0] o_clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);

  bram_clr_state_t       r_state;
  bram_clr_state_t       w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Terminal-count compare, so the sweep leaves CLEAR only after the last entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy     = (r_state == ST_CLEAR);
  assign o_clr_we   = (r_state == ST_CLEAR);
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/bram_nr_1w_clr.sv
// rtl/bram_nr_1w_clr.sv - register-file bank: NUM_RD registered read ports, byte-masked write, bypass, hw clear
module bram_nr_1w_clr
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int ADDR_DEPTH = 1 << ADDR_WIDTH,
  parameter int NUM_RD     = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_clr_req,
  output logic                           o_busy,
  input  logic [NUM_RD-1:0]              i_re,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   i_ra,
  output logic [NUM_RD*DATA_WIDTH-1:0]   o_do,
  input  logic                           i_we,
  input  logic [ADDR_WIDTH-1:0]          i_wa,
  input  logic [bytes_of(DATA_WIDTH)-1:0] i_wmask,
  input  logic [DATA_WIDTH-1:0]          i_di
);

  logic [DATA_WIDTH-1:0] r_mem [ADDR_DEPTH];

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_user_we;
  logic [DATA_WIDTH-1:0] w_merged;

  bram_clr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_DEPTH (ADDR_DEPTH)
  ) u_clr_ctrl (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr_req  (i_clr_req),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // A clear request in the same cycle as a write wins and drops the write.
  assign w_user_we = i_we & ~w_busy & ~i_clr_req;
  assign w_merged  = DATA_WIDTH'(byte_merge(MERGE_MAX_WIDTH'(r_mem[i_wa]),
                                            MERGE_MAX_WIDTH'(i_di),
                                            MERGE_MAX_BYTES'(i_wmask)));

  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_user_we) begin
      r_mem[i_wa] <= w_merged;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] r_do;

    assign w_ra = i_ra[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Write-first: a same-address read sees the post-write merged word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_do <= '0;
      end else if (i_re[k]) begin
        if (w_busy) begin
          r_do <= '0;
        end else if (w_user_we && (w_ra == i_wa)) begin
          r_do <= w_merged;
        end else begin
          r_do <= r_mem[w_ra];
        end
      end
    end

    assign o_do[k*DATA_WIDTH +: DATA_WIDTH] = r_do;
  end

  assign o_busy = w_busy;

endmodule

// File: tb/tb_bram_nr_1w_clr.sv
// tb/tb_bram_nr_1w_clr.sv - self-checking bench for bram_nr_1w_clr
module tb_bram_nr_1w_clr;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NR    = 3;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_req;
  logic          busy;
  logic [NR-1:0] re;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] dout;
  logic          we;
  logic [AW-1:0] wa;
  logic [3:0]    wmask;
  logic [DW-1:0] di;

  always #5 clk = ~clk;

  bram_nr_1w_clr #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ADDR_DEPTH (DEPTH),
    .NUM_RD     (NR)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clr_req (clr_req),
    .o_busy    (busy),
    .i_re      (re),
    .i_ra      (ra),
    .o_do      (dout),
    .i_we      (we),
    .i_wa      (wa),
    .i_wmask   (wmask),
    .i_di      (di)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_do  [NR];
  int            m_left;

  typedef struct {
    logic [2:0]  re;
    logic [3:0]  a0, a1, a2;
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  wm;
    logic [31:0] di;
    logic [31:0] e0, e1, e2;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_w & ~bm) | (new_w & bm);
  endfunction

  task automatic model_reset();
    m_left = DEPTH;
    for (int k = 0; k < NR; k++) m_do[k] = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // One clock of stimulus; reference model updated, then outputs compared after the edge.
  task automatic cyc(input logic [2:0] c_re, input logic [3:0] a0, input logic [3:0] a1,
                     input logic [3:0] a2, input logic c_we, input logic [3:0] c_wa,
                     input logic [3:0] c_wm, input logic [31:0] c_di, input logic c_clr);
    logic [3:0] a [NR];
    a[0] = a0; a[1] = a1; a[2] = a2;
    re = c_re; ra = {a2, a1, a0}; we = c_we; wa = c_wa; wmask = c_wm; di = c_di;
    clr_req = c_clr;
    if (m_left > 0) begin
      for (int k = 0; k < NR; k++) if (c_re[k]) m_do[k] = '0;
      m_left--;
    end else begin
      if (c_we && !c_clr) m_mem[c_wa] = merge(m_mem[c_wa], c_di, c_wm);
      for (int k = 0; k < NR; k++) if (c_re[k]) m_do[k] = m_mem[a[k]];
      if (c_clr) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_left = DEPTH;
      end
    end
    @(posedge clk);
    #1;
    chk("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
    for (int k = 0; k < NR; k++) chk($sformatf("do%0d", k), dout[k*DW +: DW], m_do[k]);
    re = '0; we = 1'b0; clr_req = 1'b0;
  endtask

  task automatic idle();
    cyc(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic count_busy(input bit noisy, output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (noisy)
        cyc(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), n[0],
            4'($urandom), 4'hF, $urandom, (n == 5));
      else
        idle();
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      cyc(3'b111, 4'(a), 4'(a), 4'(a), 1'b0, 4'd0, 4'd0, 32'd0, 1'b0);
      for (int k = 0; k < NR; k++)
        chk($sformatf("%s_a%0d_do%0d", tag, a, k), dout[k*DW +: DW], 32'd0);
    end
  endtask

  initial begin
    int n;
    logic [3:0] r_wa;

    tbl[0] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 4'hF, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    tbl[1] = '{3'b111, 4'd5, 4'd5, 4'd5, 1'b0, 4'd0, 4'h0, 32'h0,
               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{3'b010, 4'd0, 4'd5, 4'd0, 1'b1, 4'd5, 4'b0101, 32'h11223344,
               32'hDEADBEEF, 32'hDE22BE44, 32'hDEADBEEF};
    tbl[3] = '{3'b111, 4'd5, 4'd5, 4'd5, 1'b0, 4'd0, 4'h0, 32'h0,
               32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44};
    tbl[4] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 4'hF, 32'hA5A5A5A5,
               32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44};
    tbl[5] = '{3'b010, 4'd3, 4'd3, 4'd3, 1'b0, 4'd0, 4'h0, 32'h0,
               32'hDE22BE44, 32'hA5A5A5A5, 32'hDE22BE44};
    tbl[6] = '{3'b001, 4'd3, 4'd0, 4'd0, 1'b1, 4'd3, 4'h0, 32'hFFFFFFFF,
               32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDE22BE44};
    tbl[7] = '{3'b100, 4'd0, 4'd0, 4'd9, 1'b1, 4'd9, 4'b1000, 32'h12345678,
               32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12000000};
    tbl[8] = '{3'b111, 4'd9, 4'd5, 4'd3, 1'b1, 4'd5, 4'hF, 32'h00000000,
               32'h12000000, 32'h00000000, 32'hA5A5A5A5};

    rst_n = 1'b0; clr_req = 1'b0; re = '0; ra = '0; we = 1'b0; wa = '0; wmask = '0; di = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) chk($sformatf("rst_do%0d", k), dout[k*DW +: DW], 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b1;

    count_busy(1'b0, n);
    chk("init_busy_len", 32'(n), 32'd16);
    read_all_zero("init");

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].re, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].we, tbl[i].wa,
          tbl[i].wm, tbl[i].di, 1'b0);
      chk($sformatf("tbl%0d_do0", i), dout[31:0],  tbl[i].e0);
      chk($sformatf("tbl%0d_do1", i), dout[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d_do2", i), dout[95:64], tbl[i].e2);
    end

    cyc(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd7, 4'hF, 32'hCAFEF00D, 1'b1);
    count_busy(1'b1, n);
    chk("clr_busy_len", 32'(n), 32'd16);
    cyc(3'b011, 4'd3, 4'd7, 4'd0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0);
    chk("clr_ram3", dout[31:0],  32'd0);
    chk("clr_ram7", dout[63:32], 32'd0);

    cyc(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2, 4'hF, 32'h0BADF00D, 1'b0);
    cyc(3'b111, 4'd2, 4'd2, 4'd2, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0);
    chk("pre_rst_do0", dout[31:0], 32'h0BADF00D);
    cyc(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1);
    repeat (8) idle();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) chk($sformatf("midrst_do%0d", k), dout[k*DW +: DW], 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_busy(1'b0, n);
    chk("midrst_busy_len", 32'(n), 32'd16);
    read_all_zero("midrst");

    for (int i = 0; i < 400; i++) begin
      r_wa = 4'($urandom);
      cyc(3'($urandom),
          ($urandom_range(0, 2) == 0) ? r_wa : 4'($urandom),
          ($urandom_range(0, 2) == 0) ? r_wa : 4'($urandom),
          ($urandom_range(0, 2) == 0) ? r_wa : 4'($urandom),
          1'($urandom), r_wa, 4'($urandom), $urandom,
          ($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_nr_1w_clr.md
Name: bram_nr_1w_clr

Overview:
- Parametrised successor to the 3-read/1-write register-file RAM.
- Provides NUM_RD registered read ports, one byte-masked write port, and write-to-read bypass.
- Includes a hardware clear sequencer that zeroes every entry after reset and on request.
- Serves as the per-SIMD-lane register file bank in the GPGPU core; `busy` gates issue until the bank is clean.

Parameters:
- DATA_WIDTH, 32, bits per entry; must be a multiple of 8.
- ADDR_WIDTH, 10, address bits.
- ADDR_DEPTH, 1 << ADDR_WIDTH, number of entries.
- NUM_RD, 3, number of read ports; must be ≥ 1.

Ports:
- clk  in  1  clock; all sequential logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- clr_req  in  1  single-cycle pulse; request to zero the whole array.
- busy  out  1  high while the clear sequence runs.
- re  in  NUM_RD  per-port read enable.
- ra  in  NUM_RD*ADDR_WIDTH  read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- do  out  NUM_RD*DATA_WIDTH  registered read data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- we  in  1  write enable.
- wa  in  ADDR_WIDTH  write address.
- wmask  in  DATA_WIDTH/8  byte write mask; 1 = write that byte.
- di  in  DATA_WIDTH  write data.

Behaviour:
- Reset (rst_n low, async):
  - do = 0 on all ports.
  - State = CLEAR, clear counter = 0, busy = 1.
  - Array contents are not reset directly; the CLEAR sweep zeroes them after reset releases.
- States:
  - IDLE: normal operation. clr_req=1 -> CLEAR with counter = 0.
  - CLEAR: each cycle writes 0 to ram[counter], then counter++. When counter == ADDR_DEPTH-1 is written -> IDLE.
- Clear timing: the sweep takes exactly ADDR_DEPTH cycles. busy equals (state == CLEAR) and is registered, so busy deasserts on the edge that writes the last entry.
- During CLEAR:
  - we is ignored and the write is dropped, with no error flag.
  - clr_req is ignored; the counter does not restart.
  - A read with re[k]=1 loads do[k] = 0; with re[k]=0, do[k] holds.
- IDLE + clr_req + we in the same cycle: the clear wins and the write is dropped.
- Write (IDLE, we=1): on posedge, for each byte b with wmask[b]=1, ram[wa] byte b <= di byte b. Unmasked bytes keep their value. wmask = 0 is a legal no-op.
- Read: 1-cycle latency.
  - re[k]=1 at edge N -> do[k] valid after edge N, held until the next edge where re[k]=1.
  - re[k]=0 -> do[k] holds its previous value.
- Bypass: IDLE, we=1, re[k]=1 and ra[k]==wa in the same cycle.
  - do[k] = per byte: masked bytes take di, unmasked bytes take the old ram[wa].
  - Result is write-first, identical to reading the post-write contents.
- Ports are independent. Multiple ports may read the same address, including the bypassed one.
- Reset mid-CLEAR: the sequence restarts from entry 0 after rst_n releases.
- Address range: addresses are always in range (full 2^ADDR_WIDTH decode) and wrap naturally. The counter is ADDR_WIDTH+1 bits or uses terminal-count compare; it never wraps silently into IDLE early.

Decomposition:
- Package bram_pkg:
  - typedef enum logic {ST_IDLE, ST_CLEAR} bram_clr_state_t.
  - Function bytes_of(DATA_WIDTH).
  - Function byte_merge(old, new, mask), shared by the write path and the bypass path.
- Sub-module bram_clr_ctrl (clk, rst_n, clr_req, busy, clr_we, clr_addr), containing the FSM and counter.
- Top level: memory array, write mux (clear vs user), and a generate loop over NUM_RD for read registers and bypass.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=4, NUM_RD=3):
- Release rst_n, count cycles.
  - Expected: busy=1 for exactly 16 cycles then 0.
  - Expected: reading all 16 addresses returns 0x00000000; do=0 during reset.
- IDLE write wa=5, di=0xDEADBEEF, wmask=4'b1111; then re=3'b111, ra={5,5,5}.
  - Expected: all do ports = 0xDEADBEEF one cycle later.
- Mask merge: ram[5]=0xDEADBEEF; write di=0x11223344, wmask=4'b0101.
  - Expected: ram[5] = 0xDE22BE44.
  - Expected: the same-cycle read of port 1 at ra=5 returns 0xDE22BE44 (bypass).
- Hold: re=3'b010 with ra[0] changed.
  - Expected: do[0] and do[2] unchanged; do[1] updates.
- Mid-operation clear:
  - ram[3]=0xA5A5A5A5; pulse clr_req together with we to wa=7.
  - Expected: busy for 16 cycles.
  - Expected: we pulses and a second clr_req during CLEAR have no effect.
  - Expected: afterwards ram[3]=0 and ram[7]=0.
- Assert rst_n low at clear count 8.
  - Expected: do=0 immediately.
  - Expected: after release, busy lasts a full 16 cycles and all entries read 0.
